// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: latches EXST requests, runs them on a req/ack bus.
// Optional bus timeout/abort compiled in with `define MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          mem_force,
  output logic [DW-1:0] rdata,
  output logic          mem_err,
  output logic          busy,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          slot_q;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      BUSY: begin
        // ack beats a coincident timeout
        if (bus_ack) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (slot_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      slot_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= req;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus_req   = (state_q == BUSY);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign mem_force = slot_q && (state_q != DONE);

`ifdef MEM_TIMEOUT_EN
  assign mem_err = slot_q && (state_q == DONE) && err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: CPU poll/retry loop plus a wait-state slave.
// Two instances: TIMEOUT=4 for abort cases, TIMEOUT=255 for long waits.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, req_we;
  logic [15:0] req_addr, req_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        sel;

  logic        a_mf, a_err, a_busy, a_breq, a_bwe;
  logic [15:0] a_rd, a_addr, a_wd;
  logic        b_mf, b_err, b_busy, b_breq, b_bwe;
  logic [15:0] b_rd, b_addr, b_wd;

  logic        o_mf, o_err, o_busy, o_breq, o_bwe;
  logic [15:0] o_rd, o_addr, o_wd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.AW(16), .DW(16), .TIMEOUT(4)) u_a (
    .clk(clk), .resetn(resetn), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_force(a_mf), .rdata(a_rd), .mem_err(a_err), .busy(a_busy),
    .bus_req(a_breq), .bus_we(a_bwe), .bus_addr(a_addr),
    .bus_wdata(a_wd), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  mem_stage_ctrl #(.AW(16), .DW(16), .TIMEOUT(255)) u_b (
    .clk(clk), .resetn(resetn), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_force(b_mf), .rdata(b_rd), .mem_err(b_err), .busy(b_busy),
    .bus_req(b_breq), .bus_we(b_bwe), .bus_addr(b_addr),
    .bus_wdata(b_wd), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  assign o_mf   = sel ? b_mf   : a_mf;
  assign o_err  = sel ? b_err  : a_err;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_breq = sel ? b_breq : a_breq;
  assign o_bwe  = sel ? b_bwe  : a_bwe;
  assign o_rd   = sel ? b_rd   : a_rd;
  assign o_addr = sel ? b_addr : a_addr;
  assign o_wd   = sel ? b_wd   : a_wd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One access: req at cycle T, then alternating MEM slot / EXST retry.
  task automatic run_txn(input logic s, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int waits, input logic [15:0] ackd,
                         input logic [15:0] exp_rd, input logic exp_err,
                         input logic silent);
    int ack_k, done_k;
    bit fin;
    fin = 1'b0;
    sel = s;
    ack_k = silent ? 4 : 1 + waits;
    done_k = ack_k + 1;
    @(negedge clk);
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    bus_ack = 1'b0; bus_rdata = 16'hDEAD;
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(negedge clk);
      chk($sformatf("bus_req k=%0d", k), int'(o_breq), int'(k <= ack_k));
      if (k <= ack_k) begin
        chk("bus_we", int'(o_bwe), int'(we));
        chk("bus_addr", int'(o_addr), int'(addr));
        chk("bus_wdata", int'(o_wd), int'(wdata));
      end
      if (k % 2 == 1) begin
        chk($sformatf("mem_force k=%0d", k), int'(o_mf), int'(k < done_k));
        if (k >= done_k) begin
          chk("rdata", int'(o_rd), int'(exp_rd));
          chk("mem_err", int'(o_err), int'(exp_err));
          fin = 1'b1;
        end else begin
          chk("mem_err early", int'(o_err), 0);
        end
      end
      if (fin) begin
        req = 1'b0; bus_ack = 1'b0; bus_rdata = 16'hDEAD;
      end else begin
        bus_ack = !silent && (k == ack_k);
        bus_rdata = bus_ack ? ackd : 16'hDEAD;
        req = (k % 2 == 0);
        req_we = ~we; req_addr = 16'hFFFF; req_wdata = 16'h0000;
      end
    end
    if (!fin) chk("txn completion timeout", 0, 1);
  endtask

  typedef struct {
    logic        s;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] ackd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'h5A5A, 5, 16'h1111, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 3, 16'h1357, 16'h1357};
    vecs[3] = '{1'b0, 1'b1, 16'h00A0, 16'hC3C3, 1, 16'h2222, 16'h1357};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 2, 16'h8001, 16'h8001};
    vecs[5] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 0, 16'h7E7E, 16'h7E7E};

    sel = 1'b0; resetn = 1'b0; req = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    #1;
    chk("rst mem_force", int'(o_mf), 0);
    chk("rst bus_req", int'(o_breq), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst rdata", int'(o_rd), 0);
    chk("rst bus_addr", int'(o_addr), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].waits, vecs[i].ackd, vecs[i].exp_rd, 1'b0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_txn(1'b0, 1'b0, 16'h0BAD, 16'h0000, 0, 16'h0000,
            16'h0000, 1'b1, 1'b1);
    chk("busy after abort", int'(o_busy), 0);
`endif

    // reset in the middle of a BUSY access
    sel = 1'b0;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_addr = 16'h0ABC; req_wdata = 16'h9999;
    @(negedge clk);
    req = 1'b0;
    chk("pre-rst bus_req", int'(o_breq), 1);
    @(negedge clk);
    chk("pre-rst busy", int'(o_busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst bus_req", int'(o_breq), 0);
    chk("midrst busy", int'(o_busy), 0);
    chk("midrst bus_we", int'(o_bwe), 0);
    chk("midrst bus_addr", int'(o_addr), 0);
    chk("midrst bus_wdata", int'(o_wd), 0);
    chk("midrst rdata", int'(o_rd), 0);
    chk("midrst mem_force", int'(o_mf), 0);
    chk("midrst mem_err", int'(o_err), 0);
    @(negedge clk);
    resetn = 1'b1;
    run_txn(1'b0, 1'b0, 16'h0044, 16'h0000, 1, 16'h4242,
            16'h4242, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0046, 16'h0000, 2, 16'h6464,
            16'h6464, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Data-memory access controller serving the CPU's MEM stage; it is the responder side of the stage FSM's `EXSTtoMEM_Wen` / `mem_force` handshake. It latches a load or store request at the end of EXST and runs it on a req/ack memory bus with arbitrary wait states. Each CPU MEM cycle is treated as a poll: `mem_force` sends the CPU back to EXST until the access has completed. The block sits between the core datapath and the data-memory bus.

## Interface
Parameters:
- `AW`, 16, address width.
- `DW`, 16, data width.
- `TIMEOUT`, 255, maximum bus wait cycles before abort (range 1..65535).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request strobe; driven by `EXSTtoMEM_Wen` and high for one cycle in each EXST of a memory instruction.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  AW  access address.
- `req_wdata`  in  DW  store data.
- `mem_force`  out  1  high in a CPU MEM cycle whose access is not yet complete.
- `rdata`  out  DW  load result register, valid in the completing MEM cycle.
- `mem_err`  out  1  high in the completing MEM cycle if the access timed out.
- `busy`  out  1  state != IDLE.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  AW  bus address.
- `bus_wdata`  out  DW  bus write data.
- `bus_rdata`  in  DW  bus read data, sampled with `bus_ack`.
- `bus_ack`  in  1  single-cycle completion from the slave.

## Operation
- States: IDLE, BUSY, DONE. All state is held in registers.
- `slot` is an internal register: `slot <= req`. It is high exactly in the CPU's MEM cycle.
- IDLE:
  - On `req`, latch `req_we`, `req_addr` and `req_wdata` into the bus registers.
  - Clear the timeout counter and `err`.
  - Go to BUSY.
- BUSY:
  - `bus_req` = 1, with `bus_we`, `bus_addr` and `bus_wdata` held stable.
  - On `bus_ack`: if the access is a load, `rdata <= bus_rdata`. Go to DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT-1` with no ack: `err <= 1`, `rdata <= 0`, go to DONE.
- DONE: wait for `slot`. In the slot cycle the access completes; go to IDLE.
- `mem_force = slot && state != DONE`. This is combinational from registers only.
- `mem_err = slot && state == DONE && err`.
- `req` in BUSY or DONE is a retry strobe from the CPU re-running EXST. It is ignored, and the latched address and data are not overwritten.
- `bus_ack` outside BUSY is ignored.

## Timing
- Reset value of every output is 0; the state resets to IDLE, and `slot`, the counter and `err` reset to 0.
- Reset is asynchronous. `bus_req` drops in the same cycle that `resetn` falls, including in the middle of an access.
- With `req` at cycle T:
  - `bus_req` rises at T+1.
  - `slot` is at T+1, and `mem_force` = 1 there unless the state is already DONE. It cannot be DONE at T+1, so `mem_force` = 1.
- Zero-wait slave (ack at T+1): DONE at T+2. The CPU runs EXST at T+2 and MEM at T+3, with `mem_force` = 0 at T+3. Minimum is two MEM slots per access.
- `bus_req` falls the cycle after `bus_ack` is sampled.
- `bus_ack` and the timeout in the same cycle: ack wins, and `err` stays 0.
- `rdata` is stable from DONE entry until the next access's completion.
- Counter width is `clog2(TIMEOUT+1)`. The counter saturates and does not wrap.

## Configuration
- `MEM_TIMEOUT_EN`:
  - Defined: the timeout counter and abort behaviour are compiled in.
  - Undefined: the counter is removed, BUSY waits indefinitely for `bus_ack`, and `mem_err` is tied to 0.

## Test plan
- Zero-wait load: `req` at T with addr 0x0040; slave acks at T+1 with 0xBEEF. Required: `mem_force` = 1 at T+1, `mem_force` = 0 and `rdata` = 0xBEEF at T+3, `bus_req` high only at T+1.
- Store with 5 wait states, addr 0x1234, data 0x5A5A. Required: `bus_req`, `bus_we` = 1 and address/data stable for 6 cycles; `mem_force` = 1 on every slot until DONE; `mem_err` = 0.
- Retry `req` with addr 0xFFFF during BUSY. Required: `bus_addr` remains 0x1234.
- Silent slave with `TIMEOUT` = 4 and `MEM_TIMEOUT_EN` defined. Required: `bus_req` high for 4 cycles then low; next slot has `mem_force` = 0, `mem_err` = 1, `rdata` = 0.
- `bus_ack` on the 4th BUSY cycle with `TIMEOUT` = 4. Required: `mem_err` = 0 and data captured.
- `resetn` low mid-BUSY. Required: all outputs 0 immediately; after release, a fresh `req` completes normally.
